// File: rtl/obf_key_pkg.sv
// Shared types and sizing helpers for the obfuscated-core key loader.
package obf_key_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ARMED = 2'd1,
      S_START = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   function automatic int nwords(input int key_w, input int word_w);
      return (key_w + word_w - 1) / word_w;
   endfunction

   function automatic int last_bits(input int key_w, input int word_w);
      return key_w - (nwords(key_w, word_w) - 1) * word_w;
   endfunction

   function automatic int idx_w(input int key_w, input int word_w);
      return (nwords(key_w, word_w) > 1) ? $clog2(nwords(key_w, word_w)) : 1;
   endfunction

endpackage

// File: rtl/key_word_buffer.sv
// Word-addressed key register; the top word keeps only its low LAST_BITS bits.
module key_word_buffer
   import obf_key_pkg::*;
#(
   parameter int KEY_W  = 1535,
   parameter int WORD_W = 32,
   localparam int NW    = nwords(KEY_W, WORD_W),
   localparam int LB    = last_bits(KEY_W, WORD_W),
   localparam int IW    = idx_w(KEY_W, WORD_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic [IW-1:0]     idx,
   input  logic [WORD_W-1:0] data,
   output logic [KEY_W-1:0]  key
);

   for (genvar i = 0; i < NW; i++) begin : g_word
      localparam int BW = (i == NW - 1) ? LB : WORD_W;
      logic [BW-1:0] word_q;

      always_ff @(posedge clk) begin
         if (rst || clr)
            word_q <= '0;
         else if (we && idx == IW'(i))
            word_q <= data[BW-1:0];
      end

      assign key[i*WORD_W +: BW] = word_q;
   end

endmodule

// File: rtl/obf_key_loader.sv
// Streams the working key into a register, then sequences ap_ctrl_hs runs of the locked core.
module obf_key_loader
   import obf_key_pkg::*;
#(
   parameter int KEY_W  = 1535,
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              key_valid,
   input  logic [WORD_W-1:0] key_data,
   output logic              key_ready,
   input  logic              key_clear,
   input  logic              run_req,
   output logic              run_err,
   output logic              run_done,
   output logic [CNT_W-1:0]  run_count,
   output logic              key_loaded,
   output logic              busy,
   output logic [KEY_W-1:0]  working_key,
   output logic              core_start,
   input  logic              core_ready,
   input  logic              core_done,
   input  logic              core_idle
);

   localparam int NW = nwords(KEY_W, WORD_W);
   localparam int IW = idx_w(KEY_W, WORD_W);

   state_t          state, state_nx;
   logic [IW-1:0]   idx;
   logic [KEY_W-1:0] key_q;
   logic            accept, last_word, finish, clr_key;
   logic            unused_idle;

   assign unused_idle = core_idle;

   // a clear in the same cycle as a word discards that word
   assign accept    = (state == S_EMPTY) && key_valid && !key_clear;
   assign last_word = accept && (idx == IW'(NW - 1));
   assign clr_key   = key_clear && ((state == S_EMPTY) || (state == S_ARMED));
   assign finish    = ((state == S_START) && core_ready && core_done) ||
                      ((state == S_WAIT) && core_done);

   always_ff @(posedge ap_clk) begin
      if (ap_rst) state <= S_EMPTY;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_EMPTY: if (last_word) state_nx = S_ARMED;
         S_ARMED: begin
            if (key_clear)    state_nx = S_EMPTY;
            else if (run_req) state_nx = S_START;
         end
         S_START: if (core_ready) state_nx = core_done ? S_ARMED : S_WAIT;
         S_WAIT:  if (core_done)  state_nx = S_ARMED;
         default: state_nx = S_EMPTY;
      endcase
   end

   always_comb begin
      key_ready  = (state == S_EMPTY);
      key_loaded = (state != S_EMPTY);
      busy       = (state == S_START) || (state == S_WAIT);
      core_start = (state == S_START);
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst || (key_clear && state == S_EMPTY) || last_word)
         idx <= '0;
      else if (accept)
         idx <= idx + 1'b1;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         run_err   <= 1'b0;
         run_done  <= 1'b0;
         run_count <= '0;
      end else begin
         run_err  <= (state == S_EMPTY) && run_req;
         run_done <= finish;
         if (finish) run_count <= run_count + 1'b1;
      end
   end

   key_word_buffer #(
      .KEY_W  (KEY_W),
      .WORD_W (WORD_W)
   ) u_buf (
      .clk  (ap_clk),
      .rst  (ap_rst),
      .clr  (clr_key),
      .we   (accept),
      .idx  (idx),
      .data (key_data),
      .key  (key_q)
   );

   // the partially assembled key never reaches the core
   assign working_key = key_loaded ? key_q : '0;

endmodule

// File: tb/tb_obf_key_loader.sv
// Randomized bench for obf_key_loader with a behavioural key/run model and a reactive core stub.
module tb_obf_key_loader;

   localparam int KEY_W  = 1535;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 8;
   localparam int NW     = 48;

   logic              ap_clk = 1'b0;
   logic              ap_rst;
   logic              key_valid;
   logic [WORD_W-1:0] key_data;
   logic              key_ready;
   logic              key_clear;
   logic              run_req;
   logic              run_err;
   logic              run_done;
   logic [CNT_W-1:0]  run_count;
   logic              key_loaded;
   logic              busy;
   logic [KEY_W-1:0]  working_key;
   logic              core_start;
   logic              core_ready;
   logic              core_done;
   logic              core_idle;

   obf_key_loader #(.KEY_W(KEY_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .key_valid(key_valid), .key_data(key_data),
      .key_ready(key_ready), .key_clear(key_clear), .run_req(run_req), .run_err(run_err),
      .run_done(run_done), .run_count(run_count), .key_loaded(key_loaded), .busy(busy),
      .working_key(working_key), .core_start(core_start), .core_ready(core_ready),
      .core_done(core_done), .core_idle(core_idle)
   );

   always #5 ap_clk = ~ap_clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string nm, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
      int first;
      total++;
      if (act !== exp) begin
         bad++;
         first = -1;
         for (int b = 0; b < KEY_W; b++) if (first < 0 && act[b] !== exp[b]) first = b;
         $display("FAIL %s: first differing bit %0d got %b want %b at %0t",
                  nm, first, act[first], exp[first], $time);
      end
   endtask

   // behavioural model: what the loader must show after each clock edge
   bit               m_loaded, m_run, m_start, m_err, m_done;
   int               m_n, m_cnt;
   logic [KEY_W-1:0] m_key;

   task automatic mdl_step();
      bit fin;
      if (ap_rst) begin
         m_loaded = 0; m_run = 0; m_start = 0; m_err = 0; m_done = 0;
         m_n = 0; m_cnt = 0; m_key = '0;
         return;
      end
      m_err = 0; m_done = 0;
      if (!m_loaded) begin
         if (run_req) m_err = 1;
         if (key_clear) begin
            m_n = 0; m_key = '0;
         end else if (key_valid) begin
            for (int b = 0; b < WORD_W; b++)
               if (m_n * WORD_W + b < KEY_W) m_key[m_n * WORD_W + b] = key_data[b];
            m_n++;
            if (m_n == NW) begin m_loaded = 1; m_n = 0; end
         end
      end else if (!m_run) begin
         if (key_clear) begin
            m_loaded = 0; m_key = '0;
         end else if (run_req) begin
            m_run = 1; m_start = 1;
         end
      end else begin
         fin = m_start ? (core_ready && core_done) : core_done;
         if (m_start && core_ready) m_start = 0;
         if (fin) begin
            m_run = 0; m_start = 0; m_done = 1;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
         end
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      mdl_step();
      @(negedge ap_clk);
   endtask

   always @(negedge ap_clk) begin
      if (chk_on) begin
         chk("key_ready",  key_ready,  !m_loaded);
         chk("key_loaded", key_loaded, m_loaded);
         chk("busy",       busy,       m_run);
         chk("core_start", core_start, m_start);
         chk("run_err",    run_err,    m_err);
         chk("run_done",   run_done,   m_done);
         chk("run_count",  64'(run_count), 64'(m_cnt));
         chk_w("working_key", working_key, m_loaded ? m_key : '0);
      end
   end

   // core stub: ap_ready on cycle rdy_dly and ap_done on cycle done_dly of each run
   int rdy_dly = 0, done_dly = 0, c_k = 0;
   bit c_act = 0;
   always @(negedge ap_clk) begin
      if (!busy) c_act = 0;
      else if (!c_act) begin c_act = 1; c_k = 0; end
      else c_k++;
      core_ready = c_act && (c_k == rdy_dly);
      core_done  = c_act && (c_k == done_dly);
      core_idle  = !c_act;
   end

   task automatic load_key(input bit pattern);
      for (int i = 0; i < NW; i++) begin
         key_valid = 1;
         key_data  = pattern ? 32'hA5A50000 + 32'(i) : $urandom;
         tick();
      end
      key_valid = 0;
   endtask

   task automatic do_run(output int starts);
      bit seen;
      starts = 0; seen = 0;
      run_req = 1;
      tick();
      run_req = 0;
      for (int n = 0; n < 64 && !seen; n++) begin
         if (core_start) starts++;
         if (run_done) seen = 1;
         else tick();
      end
      chk("run_finished", seen, 1);
   endtask

   logic [KEY_W-1:0] k1;
   int starts;

   initial begin
      ap_rst = 1; key_valid = 0; key_data = '0; key_clear = 0; run_req = 0;
      tick(); tick();
      ap_rst = 0;
      chk_on = 1;
      chk("rst_key_ready", key_ready, 1);
      chk("rst_core_start", core_start, 0);
      chk("rst_run_count", 64'(run_count), 0);
      chk_w("rst_working_key", working_key, '0);

      load_key(1);
      chk("load_key_loaded", key_loaded, 1);
      chk("load_key_ready", key_ready, 0);
      chk("load_word0", 64'(working_key[31:0]), 64'h A5A50000);
      chk("load_last", 64'(working_key[1534:1504]), 64'h25A5002F);
      k1 = m_key;

      key_clear = 1; tick(); key_clear = 0;
      for (int i = 0; i < NW; i++) begin
         key_valid = 0; key_data = $urandom; tick();
         key_valid = 1; key_data = 32'hA5A50000 + 32'(i); tick();
      end
      key_valid = 0;
      chk_w("gated_key", working_key, k1);

      rdy_dly = 3; done_dly = 10;
      do_run(starts);
      chk("slow_starts", 64'(starts), 4);
      chk("slow_count", 64'(run_count), 1);

      rdy_dly = 0; done_dly = 0;
      for (int r = 0; r < 3; r++) begin
         do_run(starts);
         chk("fast_starts", 64'(starts), 1);
      end
      chk("fast_count", 64'(run_count), 4);

      key_clear = 1; tick(); key_clear = 0;
      run_req = 1; tick(); run_req = 0;
      chk("err_pulse", run_err, 1);
      chk("err_no_start", core_start, 0);
      tick();
      chk("err_one_cycle", run_err, 0);

      load_key(0);
      key_clear = 1; run_req = 1; tick(); key_clear = 0; run_req = 0;
      chk("clr_wins_loaded", key_loaded, 0);
      chk("clr_wins_err", run_err, 0);
      chk_w("clr_wins_key", working_key, '0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (!busy) begin
            rdy_dly  = $urandom_range(0, 3);
            done_dly = rdy_dly + $urandom_range(0, 5);
         end
         ap_rst    = ($urandom_range(0, 699) == 0);
         key_valid = ($urandom_range(0, 3) != 0);
         key_data  = $urandom;
         key_clear = ($urandom_range(0, 59) == 0);
         run_req   = ($urandom_range(0, 5) == 0);
         tick();
      end
      ap_rst = 0; key_valid = 0; key_clear = 0; run_req = 0;

      // reset in the middle of a run
      tick(); tick();
      if (busy) begin
         for (int n = 0; n < 64 && busy; n++) tick();
      end
      if (!key_loaded) load_key(0);
      rdy_dly = 1; done_dly = 20;
      run_req = 1; tick(); run_req = 0;
      for (int n = 0; n < 10 && !(busy && !core_start); n++) tick();
      chk("wait_reached", busy && !core_start, 1);
      ap_rst = 1; tick(); ap_rst = 0;
      chk("rst_run_busy", busy, 0);
      chk("rst_run_start", core_start, 0);
      chk("rst_run_loaded", key_loaded, 0);
      chk("rst_run_count", 64'(run_count), 0);
      chk_w("rst_run_key", working_key, '0);

      // counter wrap
      load_key(1);
      rdy_dly = 0; done_dly = 0;
      for (int r = 0; r < 255; r++) do_run(starts);
      chk("wrap_full", 64'(run_count), 64'hFF);
      do_run(starts);
      chk("wrap_zero", 64'(run_count), 0);
      chk("wrap_done", run_done, 1);

      tick();
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
